raster_timing_ctl: RTL and testbench
====================================

# raster_timing_ctl

Sequences the chip-model timing configuration for the raster counter. Owns the active `chip` selection, derives `raster_x_max`/`raster_y_max`, and maintains `cycle_num` from `dot_rising_0`. Accepts chip-switch requests over a valid/ready handshake and applies each switch only at the end-of-frame dot, holding the raster block in reset for a fixed number of clocks while the switch takes effect. Sits between the register/config interface and the raster module in the `clk_dot4x` domain.

## Interface
- `DEFAULT_CHIP`, 2'd1 — chip code loaded at reset.
- `HOLD_CYCLES`, 4 — `clk_dot4x` clocks that `raster_rst` stays high per switch; legal range 1..15.
- `TIMEOUT_DOTS`, 18'd262143 — `dot_rising_0` pulses allowed in WAIT_EOF before a forced switch; used only when the timeout feature is compiled in.

- `clk_dot4x` in 1 — the only clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `dot_rising_0` in 1 — dot strobe, one `clk_dot4x` clock wide.
- `raster_x` in 10 — current raster x from the raster module.
- `raster_line` in 9 — current raster line from the raster module.
- `chip_req` in 2 — requested chip code.
- `chip_req_valid` in 1 — request valid.
- `chip_req_ready` out 1 — request accept; combinational, equals `state==RUN`.
- `chip` out 2 — active chip code.
- `raster_x_max` out 10 — last x index of a line.
- `raster_y_max` out 9 — last line index of a frame.
- `cycle_num` out 7 — current bus cycle.
- `raster_rst` out 1 — reset to the raster module, active-high.
- `switch_done` out 1 — one-clock pulse when a request completes.
- `timeout_flag` out 1 — sticky flag; set when a switch was forced by timeout.

## Operation
- Chip codes and their limits:
  - 0 = 6567R8: 65 cycles, x_max 519, y_max 262.
  - 1 = 6569R3: 63 cycles, x_max 503, y_max 311.
  - 2 = 6567R56A: 64 cycles, x_max 511, y_max 261.
  - 3 = 6569R1: 63 cycles, x_max 503, y_max 311.
- `raster_x_max`, `raster_y_max` and cycle count are registered. They are decoded from `chip` and update on the clock after `chip` changes.
- A handshake fires when `chip_req_valid && chip_req_ready`; `chip_req` is captured into `pend_chip` on that clock.
- FSM states and transitions:
  - RUN: on handshake, go to SAME if `pend_chip==chip`, else to WAIT_EOF. Clears `timeout_flag` on handshake.
  - SAME: pulse `switch_done` for one clock, go to RUN. No reset is issued and no config changes.
  - WAIT_EOF: stay until `dot_rising_0 && raster_x==raster_x_max && raster_line==raster_y_max`. Then set `chip<=pend_chip`, `raster_rst<=1`, load the hold counter with `HOLD_CYCLES-1`, and go to HOLD.
  - HOLD: decrement the hold counter each clock. At 0, set `raster_rst<=0` and go to SETTLE.
  - SETTLE: wait for the next `dot_rising_0`, pulse `switch_done`, go to RUN.
- Cycle tracking uses a 3-bit `dot_ctr`, advanced on `dot_rising_0`:
  - While `raster_rst` is high: `dot_ctr<=0` and `cycle_num<=0`.
  - Otherwise `dot_ctr` increments. When `dot_ctr==7`, `cycle_num` increments, wrapping to 0 when it equals cycles-1.
- Any `chip_req_valid` outside RUN is ignored (ready is low) and must be held by the requester.

## Timing
- Reset values (while `rst_n==0` at a clock edge):
  - state=RUN, `chip=DEFAULT_CHIP`, limits decoded for `DEFAULT_CHIP`.
  - `cycle_num=0`, `dot_ctr=0`.
  - `raster_rst=0`, `switch_done=0`, `timeout_flag=0`.
  - Hold and timeout counters = 0.
- Reset mid-switch (any state): the FSM returns to RUN, `chip` reverts to `DEFAULT_CHIP`, the pending request is discarded, and `raster_rst` drops on the same edge.
- `raster_rst` is high for exactly `HOLD_CYCLES` clocks, starting the clock after the end-of-frame dot.
- Latency for a differing-chip request: end-of-frame dot + `HOLD_CYCLES` + wait for the next `dot_rising_0`, then 1 clock to `switch_done`.
- Latency for a same-chip request: `switch_done` on clock 2 after the handshake.
- If the handshake coincides with the end-of-frame dot, that dot does not count; the switch waits for the next frame end.
- `raster_line` and `raster_x` are compared unsigned at full width. Values beyond the max never match.

## Configuration
- `RASTER_SWITCH_TIMEOUT_EN` defined:
  - An 18-bit counter clears on entry to WAIT_EOF and increments on each `dot_rising_0` in WAIT_EOF.
  - When the counter reaches `TIMEOUT_DOTS` before end of frame, the FSM behaves as if end of frame was seen.
  - It also sets `timeout_flag`, which holds until the next handshake.
- `RASTER_SWITCH_TIMEOUT_EN` undefined: no timeout counter; WAIT_EOF waits indefinitely; `timeout_flag` is tied 0.

## Test plan
- Reset with `DEFAULT_CHIP=1`, then drive `dot_rising_0` every 4 clocks:
  - Expect `raster_x_max=503`, `raster_y_max=311`, `chip_req_ready=1`, `raster_rst=0`.
  - Expect `cycle_num` to step every 8 dots and wrap 62→0.
- Request chip 1 while `chip==1` → `switch_done` 2 clocks later; `raster_rst` never high; `chip` unchanged.
- Request chip 0 at line 100 → ready low until SETTLE completes.
  - `raster_rst` rises the clock after dot (x=503, line=311) and is high for 4 clocks.
  - Then `raster_x_max=519`, `raster_y_max=262`, `cycle_num=0`, and `switch_done` pulses once.
- Hold `chip_req_valid` during HOLD with a new code → no capture; it is accepted on the first clock back in RUN.
- Assert `rst_n=0` during HOLD → the next clock shows `raster_rst=0`, `chip=DEFAULT_CHIP`, state RUN.
- With `RASTER_SWITCH_TIMEOUT_EN` and `TIMEOUT_DOTS=1000`, freeze `raster_line` at 5 → forced switch after 1000 dots and `timeout_flag=1`. The flag clears on the next handshake.

Source files
------------

// File: rtl/raster_timing_ctl.sv
// Chip-model timing sequencer for the raster counter: owns the active chip,
// its registered line/frame limits and bus-cycle count, and applies chip
// switches at end of frame while holding the raster block in reset.
//
// Optional feature: define RASTER_SWITCH_TIMEOUT_EN to force a pending switch
// after TIMEOUT_DOTS dot strobes without an end-of-frame match.
//
// Ports:
//   clk_dot4x, rst_n        - clock, synchronous active-low reset
//   dot_rising_0            - one-clock dot strobe
//   raster_x, raster_line   - current raster position
//   chip_req/_valid/_ready  - chip-switch request handshake
//   chip, raster_x_max,
//   raster_y_max, cycle_num - active configuration and bus cycle
//   raster_rst              - active-high reset to the raster module
//   switch_done             - one-clock pulse per completed request
//   timeout_flag            - sticky: last switch was forced by timeout
module raster_timing_ctl #(
    parameter logic [1:0]  DEFAULT_CHIP = 2'd1,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter logic [17:0] TIMEOUT_DOTS = 18'd262143
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic       dot_rising_0,
    input  logic [9:0] raster_x,
    input  logic [8:0] raster_line,
    input  logic [1:0] chip_req,
    input  logic       chip_req_valid,
    output logic       chip_req_ready,
    output logic [1:0] chip,
    output logic [9:0] raster_x_max,
    output logic [8:0] raster_y_max,
    output logic [6:0] cycle_num,
    output logic       raster_rst,
    output logic       switch_done,
    output logic       timeout_flag
);

    typedef enum logic [2:0] {
        S_RUN,
        S_SAME,
        S_WAIT_EOF,
        S_HOLD,
        S_SETTLE
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    function automatic logic [9:0] dec_x(input logic [1:0] c);
        case (c)
            2'd0:    dec_x = 10'd519;
            2'd1:    dec_x = 10'd503;
            2'd2:    dec_x = 10'd511;
            default: dec_x = 10'd503;
        endcase
    endfunction

    function automatic logic [8:0] dec_y(input logic [1:0] c);
        case (c)
            2'd0:    dec_y = 9'd262;
            2'd1:    dec_y = 9'd311;
            2'd2:    dec_y = 9'd261;
            default: dec_y = 9'd311;
        endcase
    endfunction

    // Last cycle index (cycle count minus one) for the wrap compare.
    function automatic logic [6:0] dec_c(input logic [1:0] c);
        case (c)
            2'd0:    dec_c = 7'd64;
            2'd1:    dec_c = 7'd62;
            2'd2:    dec_c = 7'd63;
            default: dec_c = 7'd62;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] chip_q, chip_d;
    logic [1:0] pend_q, pend_d;
    logic [9:0] x_max_q;
    logic [8:0] y_max_q;
    logic [6:0] cyc_last_q;
    logic [6:0] cyc_q, cyc_d;
    logic [2:0] dot_ctr_q, dot_ctr_d;
    logic [3:0] hold_q, hold_d;
    logic       rrst_q, rrst_d;
    logic       done_q, done_d;
    logic       fire;
    logic       eof;
    logic       timeout_hit;

    assign fire = chip_req_valid && (state_q == S_RUN);
    // Values beyond the limits never match: plain full-width equality.
    assign eof  = dot_rising_0 && (raster_x == x_max_q)
               && (raster_line == y_max_q);

    always_comb begin
        state_d = state_q;
        chip_d  = chip_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        rrst_d  = rrst_q;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (fire) begin
                    pend_d  = chip_req;
                    state_d = (chip_req == chip_q) ? S_SAME : S_WAIT_EOF;
                end
            end
            S_SAME: begin
                done_d  = 1'b1;
                state_d = S_RUN;
            end
            S_WAIT_EOF: begin
                if (eof || timeout_hit) begin
                    chip_d  = pend_q;
                    rrst_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == 4'd0) begin
                    rrst_d  = 1'b0;
                    state_d = S_SETTLE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_SETTLE: begin
                if (dot_rising_0) begin
                    done_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Bus-cycle tracking: eight dots per cycle, held at zero during reset.
    always_comb begin
        dot_ctr_d = dot_ctr_q;
        cyc_d     = cyc_q;
        if (rrst_q) begin
            dot_ctr_d = 3'd0;
            cyc_d     = 7'd0;
        end else if (dot_rising_0) begin
            dot_ctr_d = dot_ctr_q + 3'd1;
            if (dot_ctr_q == 3'd7) begin
                cyc_d = (cyc_q == cyc_last_q) ? 7'd0 : cyc_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            chip_q     <= DEFAULT_CHIP;
            pend_q     <= DEFAULT_CHIP;
            x_max_q    <= dec_x(DEFAULT_CHIP);
            y_max_q    <= dec_y(DEFAULT_CHIP);
            cyc_last_q <= dec_c(DEFAULT_CHIP);
            cyc_q      <= 7'd0;
            dot_ctr_q  <= 3'd0;
            hold_q     <= 4'd0;
            rrst_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chip_q     <= chip_d;
            pend_q     <= pend_d;
            x_max_q    <= dec_x(chip_q);
            y_max_q    <= dec_y(chip_q);
            cyc_last_q <= dec_c(chip_q);
            cyc_q      <= cyc_d;
            dot_ctr_q  <= dot_ctr_d;
            hold_q     <= hold_d;
            rrst_q     <= rrst_d;
            done_q     <= done_d;
        end
    end

`ifdef RASTER_SWITCH_TIMEOUT_EN
    logic [17:0] to_q, to_d;
    logic        flag_q, flag_d;

    assign timeout_hit = (state_q == S_WAIT_EOF) && (to_q == TIMEOUT_DOTS);

    always_comb begin
        to_d   = to_q;
        flag_d = flag_q;
        if (fire) begin
            to_d   = 18'd0;
            flag_d = 1'b0;
        end else if (state_q == S_WAIT_EOF) begin
            if (dot_rising_0) to_d = to_q + 18'd1;
            if (timeout_hit && !eof) flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            to_q   <= 18'd0;
            flag_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_hit  = 1'b0 & (TIMEOUT_DOTS == 18'd0);
    assign timeout_flag = 1'b0;
`endif

    assign chip_req_ready = (state_q == S_RUN);
    assign chip           = chip_q;
    assign raster_x_max   = x_max_q;
    assign raster_y_max   = y_max_q;
    assign cycle_num      = cyc_q;
    assign raster_rst     = rrst_q;
    assign switch_done    = done_q;

endmodule

// File: tb/tb_raster_timing_ctl.sv
// Directed bench for raster_timing_ctl: reset values, cycle counting,
// same/different chip switches, held requests, reset mid-switch, timeout.
module tb_raster_timing_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dot;
    logic [9:0] rx;
    logic [8:0] rl;
    logic [1:0] req;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] chip;
    logic [9:0] xmax;
    logic [8:0] ymax;
    logic [6:0] cyc;
    logic       rrst;
    logic       done;
    logic       tflag;

    int errors = 0;
    int checks = 0;
    int dots_seen = 0;
    int n;
    logic [1:0] phase;

    always #5 clk = ~clk;

    raster_timing_ctl #(
        .DEFAULT_CHIP(2'd1),
        .HOLD_CYCLES (4),
        .TIMEOUT_DOTS(18'd1000)
    ) dut (
        .clk_dot4x     (clk),
        .rst_n         (rst_n),
        .dot_rising_0  (dot),
        .raster_x      (rx),
        .raster_line   (rl),
        .chip_req      (req),
        .chip_req_valid(req_valid),
        .chip_req_ready(req_ready),
        .chip          (chip),
        .raster_x_max  (xmax),
        .raster_y_max  (ymax),
        .cycle_num     (cyc),
        .raster_rst    (rrst),
        .switch_done   (done),
        .timeout_flag  (tflag)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; dot strobe presented every fourth clock.
    task automatic clk1();
        logic had;
        had = dot;
        @(posedge clk);
        #1;
        if (had) dots_seen++;
        phase = phase + 2'd1;
        dot = (phase == 2'd3);
    endtask

    task automatic run_dots(input int k);
        int t;
        t = dots_seen + k;
        while (dots_seen < t) clk1();
    endtask

    task automatic wait_dot_next();
        while (!dot) clk1();
    endtask

    task automatic wait_done(input int lim);
        n = 0;
        while (!done && n < lim) begin
            clk1();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; dot = 1'b0; phase = 2'd0;
        rx = '0; rl = '0; req = '0; req_valid = 1'b0;
        repeat (3) clk1();
        chk("rst_chip", chip, 1);
        chk("rst_xmax", xmax, 503);
        chk("rst_ymax", ymax, 311);
        chk("rst_ready", req_ready, 1);
        chk("rst_rrst", rrst, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_done", done, 0);
        chk("rst_tflag", tflag, 0);

        rst_n = 1'b1;
        dots_seen = 0;
        run_dots(8);
        chk("cyc_step", cyc, 1);
        run_dots(488);
        chk("cyc_62", cyc, 62);
        run_dots(8);
        chk("cyc_wrap", cyc, 0);

        req = 2'd1; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        chk("same_ready", req_ready, 0);
        chk("same_done_early", done, 0);
        clk1();
        chk("same_done", done, 1);
        chk("same_chip", chip, 1);
        chk("same_rrst", rrst, 0);
        clk1();
        chk("same_done_pulse", done, 0);

        rl = 9'd100;
        req = 2'd0; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        chk("sw_ready_low", req_ready, 0);
        run_dots(10);
        chk("sw_wait_ready", req_ready, 0);
        chk("sw_wait_rrst", rrst, 0);
        chk("sw_wait_chip", chip, 1);
        wait_dot_next();
        rx = 10'd503; rl = 9'd311;
        clk1();
        rx = '0; rl = '0;
        chk("sw_rrst_rise", rrst, 1);
        chk("sw_chip", chip, 0);
        chk("sw_xmax_lag", xmax, 503);
        clk1();
        chk("sw_xmax", xmax, 519);
        chk("sw_ymax", ymax, 262);
        chk("sw_rrst2", rrst, 1);
        clk1();
        chk("sw_rrst3", rrst, 1);
        clk1();
        chk("sw_rrst4", rrst, 1);
        clk1();
        chk("sw_rrst_fall", rrst, 0);
        chk("sw_settle_ready", req_ready, 0);
        wait_done(16);
        chk("sw_settle_lat", n + 4, 8);
        chk("sw_done", done, 1);
        chk("sw_cyc0", cyc, 0);
        chk("sw_ready_back", req_ready, 1);
        clk1();
        chk("sw_done_pulse", done, 0);
        run_dots(7);
        chk("sw_cyc_step", cyc, 1);

        req = 2'd2; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        chk("hq_ready", req_ready, 0);
        wait_dot_next();
        rx = 10'd519; rl = 9'd262;
        clk1();
        rx = '0; rl = '0;
        chk("hq_rrst", rrst, 1);
        chk("hq_chip", chip, 2);
        req = 2'd3; req_valid = 1'b1;
        wait_done(20);
        chk("hq_done", done, 1);
        chk("hq_no_capture", chip, 2);
        chk("hq_ready_back", req_ready, 1);
        clk1();
        req_valid = 1'b0;
        chk("hq_accepted", req_ready, 0);
        chk("hq_done_pulse", done, 0);

        wait_dot_next();
        rx = 10'd511; rl = 9'd261;
        clk1();
        rx = '0; rl = '0;
        chk("mr_rrst", rrst, 1);
        chk("mr_chip3", chip, 3);
        clk1();
        rst_n = 1'b0;
        clk1();
        chk("mr_rrst_drop", rrst, 0);
        chip_check: chk("mr_chip_def", chip, 1);
        chk("mr_ready", req_ready, 1);
        chk("mr_xmax", xmax, 503);
        rst_n = 1'b1;

        wait_dot_next();
        rx = 10'd503; rl = 9'd311;
        req = 2'd2; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        rx = 10'd503; rl = 9'd312;
        chk("hs_eof_ignored", rrst, 0);
        chk("hs_eof_ready", req_ready, 0);
        wait_dot_next();
        clk1();
        chk("line_beyond", rrst, 0);
        rx = 10'd504; rl = 9'd311;
        wait_dot_next();
        clk1();
        chk("x_beyond", rrst, 0);
        rx = 10'd503; rl = 9'd311;
        wait_dot_next();
        clk1();
        rx = '0; rl = '0;
        chk("eof_real", rrst, 1);
        chk("eof_chip", chip, 2);
        wait_done(20);
        chk("b_done", done, 1);
        chk("b_xmax", xmax, 511);
        chk("b_ymax", ymax, 261);
        chk("b_tflag", tflag, 0);

`ifdef RASTER_SWITCH_TIMEOUT_EN
        rl = 9'd5;
        req = 2'd0; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        run_dots(999);
        chk("to_not_yet", rrst, 0);
        chk("to_flag_low", tflag, 0);
        n = 0;
        while (!rrst && n < 16) begin
            clk1();
            n++;
        end
        chk("to_forced", rrst, 1);
        chk("to_chip", chip, 0);
        chk("to_flag", tflag, 1);
        wait_done(20);
        chk("to_done", done, 1);
        chk("to_flag_hold", tflag, 1);
        req = 2'd0; req_valid = 1'b1;
        clk1();
        req_valid = 1'b0;
        chk("to_flag_clear", tflag, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
